// File: rtl/matmul_pkg.sv
// matmul_pkg: shared widths and types for the systolic matrix multiplier.
// Holds operand/accumulator/dimension typedefs and a dimension clamp helper.
package matmul_pkg;

    localparam int DEF_BITS = 8;
    localparam int DEF_DIM  = 32;

    localparam int DEF_DW = $clog2(DEF_DIM) + 1;

    typedef logic [DEF_BITS-1:0]   operand_t;
    typedef logic [2*DEF_BITS-1:0] acc_t;
    typedef logic [DEF_DW-1:0]     dim_t;

    // Sizes above the array dimension behave as the full array.
    function automatic dim_t clamp_dim(dim_t v);
        return (v > dim_t'(DEF_DIM)) ? dim_t'(DEF_DIM) : v;
    endfunction

endpackage

// File: rtl/matmul_pe.sv
// matmul_pe: one multiply-accumulate cell of the output-stationary array.
// Ports: clk, rst_n (sync, active-low), step (advance enable),
//        a_in/b_in operands in, a_out/b_out registered pass-through,
//        acc running dot-product (wraps modulo 2^(2*BITS)).
module matmul_pe
    import matmul_pkg::*;
#(
    parameter int BITS = DEF_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    input  logic [BITS-1:0]   a_in,
    input  logic [BITS-1:0]   b_in,
    output logic [BITS-1:0]   a_out,
    output logic [BITS-1:0]   b_out,
    output logic [2*BITS-1:0] acc
);

    logic [2*BITS-1:0] w_prod;

    assign w_prod = (2*BITS)'(a_in) * (2*BITS)'(b_in);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc   <= '0;
            a_out <= '0;
            b_out <= '0;
        end else if (step) begin
            acc   <= acc + w_prod;
            a_out <= a_in;
            b_out <= b_in;
        end
    end

endmodule

// File: rtl/matmul.sv
// matmul: DIM x DIM output-stationary systolic multiplier, C = A x B.
// Ports: clk, rst_n (sync, active-low), en (advance), WrEn (ignored),
//        m/n/p active sizes, matrixDataA/B operands [row][col],
//        dataOut accumulator array [row][col], done sticky result-valid.
module matmul
    import matmul_pkg::*;
#(
    parameter int BITS = DEF_BITS,
    parameter int DIM  = DEF_DIM
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   en,
    input  logic                                   WrEn,
    input  logic [$clog2(DIM):0]                   m,
    input  logic [$clog2(DIM):0]                   n,
    input  logic [$clog2(DIM):0]                   p,
    input  logic [DIM-1:0][DIM-1:0][BITS-1:0]      matrixDataA,
    input  logic [DIM-1:0][DIM-1:0][BITS-1:0]      matrixDataB,
    output logic [DIM-1:0][DIM-1:0][2*BITS-1:0]    dataOut,
    output logic                                   done
);

    localparam int AW = $clog2(DIM);
    localparam int DW = AW + 1;
    localparam int CW = $clog2(3*DIM) + 1;

    logic [CW-1:0] r_c;
    logic          r_done;

    logic [DW-1:0] w_m;
    logic [DW-1:0] w_n;
    logic [DW-1:0] w_p;
    logic [CW:0]   w_sum;
    logic          w_step;
    logic          w_fin;
    logic          w_unused;

    logic [BITS-1:0] w_a_feed [DIM];
    logic [BITS-1:0] w_b_feed [DIM];
    logic [BITS-1:0] w_ah     [DIM][DIM];
    logic [BITS-1:0] w_bv     [DIM][DIM];

    assign w_unused = WrEn;

    assign w_m = (m > DW'(DIM)) ? DW'(DIM) : m;
    assign w_n = (n > DW'(DIM)) ? DW'(DIM) : n;
    assign w_p = (p > DW'(DIM)) ? DW'(DIM) : p;

    assign w_sum = (CW+1)'(w_m) + (CW+1)'(w_n) + (CW+1)'(w_p);

    assign w_step = en & ~r_done;

    // The last product lands on the edge at c = m+n+p-3, so finishing
    // on that edge means c+3 >= m+n+p. The >= also covers zero sizes.
    assign w_fin = ({1'b0, r_c} + (CW+1)'(3)) >= w_sum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_c    <= '0;
            r_done <= 1'b0;
        end else if (w_step) begin
            r_c <= r_c + 1'b1;
            if (w_fin) begin
                r_done <= 1'b1;
            end
        end
    end

    assign done = r_done;

    // Skewed edge feed. Row i and column i share the offset c - i;
    // a borrow into the MSB marks c < i.
    for (genvar i = 0; i < DIM; i++) begin : g_feed
        logic [CW:0] w_off;
        logic        w_in_k;
        logic        w_a_ok;
        logic        w_b_ok;

        assign w_off  = {1'b0, r_c} - (CW+1)'(i);
        assign w_in_k = !w_off[CW] && (w_off < (CW+1)'(w_p));
        assign w_a_ok = w_in_k && (DW'(i) < w_m);
        assign w_b_ok = w_in_k && (DW'(i) < w_n);

        assign w_a_feed[i] = w_a_ok ?
            matrixDataA[i][w_off[AW-1:0]] : '0;
        assign w_b_feed[i] = w_b_ok ?
            matrixDataB[w_off[AW-1:0]][i] : '0;
    end

    for (genvar i = 0; i < DIM; i++) begin : g_row
        for (genvar j = 0; j < DIM; j++) begin : g_col
            logic [BITS-1:0] w_ain;
            logic [BITS-1:0] w_bin;

            if (j == 0) begin : g_al
                assign w_ain = w_a_feed[i];
            end else begin : g_ai
                assign w_ain = w_ah[i][j-1];
            end

            if (i == 0) begin : g_bt
                assign w_bin = w_b_feed[j];
            end else begin : g_bi
                assign w_bin = w_bv[i-1][j];
            end

            matmul_pe #(
                .BITS (BITS)
            ) u_pe (
                .clk   (clk),
                .rst_n (rst_n),
                .step  (w_step),
                .a_in  (w_ain),
                .b_in  (w_bin),
                .a_out (w_ah[i][j]),
                .b_out (w_bv[i][j]),
                .acc   (dataOut[i][j])
            );
        end
    end

endmodule

// File: tb/tb_matmul.sv
// tb_matmul: directed self-checking bench for the systolic multiplier.
// Each task drives one scenario and checks latency and result entries.
module tb_matmul;

    localparam int DIM  = 32;
    localparam int BITS = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic WrEn;
    logic [5:0] m;
    logic [5:0] n;
    logic [5:0] p;
    logic [DIM-1:0][DIM-1:0][BITS-1:0]   A;
    logic [DIM-1:0][DIM-1:0][BITS-1:0]   B;
    logic [DIM-1:0][DIM-1:0][2*BITS-1:0] dout;
    logic done;

    logic [15:0] exp_c [DIM][DIM];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    matmul dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .WrEn        (WrEn),
        .m           (m),
        .n           (n),
        .p           (p),
        .matrixDataA (A),
        .matrixDataB (B),
        .dataOut     (dout),
        .done        (done)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run(input int budget, output int edges);
        edges = 0;
        en = 1'b1;
        while (edges < budget && done !== 1'b1) begin
            @(negedge clk);
            edges++;
        end
        en = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                A[i][j] = 8'($urandom_range(255));
                B[i][j] = 8'($urandom_range(255));
            end
        m = 32; n = 32; p = 32;
        do_reset();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got %b want 0", done);
        end
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                checks++;
                if (dout[i][j] !== 16'd0) begin
                    errors++;
                    $display("FAIL reset_out[%0d][%0d] got %0d want 0",
                             i, j, dout[i][j]);
                end
            end
    endtask

    task automatic test_5x5();
        int e;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                A[i][j] = 8'($urandom_range(100));
                B[i][j] = 8'($urandom_range(100));
            end
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                exp_c[i][j] = 16'd0;
                if (i < 5 && j < 5)
                    for (int k = 0; k < 5; k++)
                        exp_c[i][j] = exp_c[i][j] +
                            16'(A[i][k]) * 16'(B[k][j]);
            end
        m = 5; n = 5; p = 5;
        do_reset();
        run(200, e);
        checks++;
        if (e !== 13 || done !== 1'b1) begin
            errors++;
            $display("FAIL lat5 got %0d done %b want 13", e, done);
        end
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                checks++;
                if (dout[i][j] !== exp_c[i][j]) begin
                    errors++;
                    $display("FAIL c5[%0d][%0d] got %0d want %0d",
                             i, j, dout[i][j], exp_c[i][j]);
                end
            end
    endtask

    task automatic test_ones_hold();
        int e;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                A[i][j] = 8'd1;
                B[i][j] = 8'd1;
            end
        m = 32; n = 32; p = 32;
        do_reset();
        run(300, e);
        checks++;
        if (e !== 94 || done !== 1'b1) begin
            errors++;
            $display("FAIL lat32 got %0d done %b want 94", e, done);
        end
        en = 1'b1;
        repeat (5) @(negedge clk);
        en = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL hold_done got %b want 1", done);
        end
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                checks++;
                if (dout[i][j] !== 16'd32) begin
                    errors++;
                    $display("FAIL ones[%0d][%0d] got %0d want 32",
                             i, j, dout[i][j]);
                end
            end
    endtask

    task automatic test_wrap();
        int e;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                A[i][j] = 8'd255;
                B[i][j] = 8'd255;
            end
        m = 32; n = 32; p = 32;
        do_reset();
        run(300, e);
        checks++;
        if (e !== 94) begin
            errors++;
            $display("FAIL latwrap got %0d want 94", e);
        end
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                checks++;
                if (dout[i][j] !== 16'd49184) begin
                    errors++;
                    $display("FAIL wrap[%0d][%0d] got %0d want 49184",
                             i, j, dout[i][j]);
                end
            end
    endtask

    task automatic test_rect();
        int e;
        logic [15:0] want;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                A[i][j] = 8'(i + 1);
                B[i][j] = 8'(j + 1);
            end
        m = 3; n = 4; p = 2;
        do_reset();
        run(100, e);
        checks++;
        if (e !== 7 || done !== 1'b1) begin
            errors++;
            $display("FAIL latrect got %0d done %b want 7", e, done);
        end
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                want = (i < 3 && j < 4) ? 16'(2 * (i + 1) * (j + 1)) : 16'd0;
                checks++;
                if (dout[i][j] !== want) begin
                    errors++;
                    $display("FAIL rect[%0d][%0d] got %0d want %0d",
                             i, j, dout[i][j], want);
                end
            end
    endtask

    task automatic test_stall();
        int e;
        logic [15:0] want;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                A[i][j] = (i == j) ? 8'd1 : 8'($urandom_range(255));
                if (i < 8 && j < 8 && i != j)
                    A[i][j] = 8'd0;
                B[i][j] = 8'($urandom_range(255));
            end
        m = 8; n = 8; p = 8;
        do_reset();
        en = 1'b1;
        repeat (10) @(negedge clk);
        en = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL stall_done got %b want 0", done);
        end
        run(100, e);
        checks++;
        if (e !== 12 || done !== 1'b1) begin
            errors++;
            $display("FAIL stall_lat got %0d done %b want 12", e, done);
        end
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                want = (i < 8 && j < 8) ? 16'(B[i][j]) : 16'd0;
                checks++;
                if (dout[i][j] !== want) begin
                    errors++;
                    $display("FAIL ident[%0d][%0d] got %0d want %0d",
                             i, j, dout[i][j], want);
                end
            end
    endtask

    task automatic test_zero_dim();
        int e;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                A[i][j] = 8'($urandom_range(1, 255));
                B[i][j] = 8'($urandom_range(1, 255));
            end
        m = 0; n = 4; p = 4;
        do_reset();
        run(100, e);
        checks++;
        if (e !== 6 || done !== 1'b1) begin
            errors++;
            $display("FAIL zero_lat got %0d done %b want 6", e, done);
        end
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                checks++;
                if (dout[i][j] !== 16'd0) begin
                    errors++;
                    $display("FAIL zero[%0d][%0d] got %0d want 0",
                             i, j, dout[i][j]);
                end
            end
    endtask

    task automatic test_mid_reset();
        int e;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                A[i][j] = 8'd1;
                B[i][j] = 8'd1;
            end
        m = 32; n = 32; p = 32;
        do_reset();
        en = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_done got %b want 0", done);
        end
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                checks++;
                if (dout[i][j] !== 16'd0) begin
                    errors++;
                    $display("FAIL midrst[%0d][%0d] got %0d want 0",
                             i, j, dout[i][j]);
                end
            end
        run(300, e);
        checks++;
        if (e !== 94 || done !== 1'b1) begin
            errors++;
            $display("FAIL rerun_lat got %0d done %b want 94", e, done);
        end
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                checks++;
                if (dout[i][j] !== 16'd32) begin
                    errors++;
                    $display("FAIL rerun[%0d][%0d] got %0d want 32",
                             i, j, dout[i][j]);
                end
            end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        WrEn  = 1'bx;
        m = '0; n = '0; p = '0;
        A = '0; B = '0;
        @(negedge clk);
        test_reset();
        test_5x5();
        test_ones_hold();
        test_wrap();
        test_rect();
        test_stall();
        test_zero_dim();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matmul.md
# matmul

Output-stationary systolic matrix multiplier for the accelerator datapath. It computes C = A × B on unsigned 8-bit operands held in DIM×DIM register arrays and writes 16-bit results into a DIM×DIM output array. The active sub-matrix sizes are set at run time by m, n and p. It sits between the feature-map buffers, which supply whole matrices in parallel, and downstream logic, which samples dataOut when done is high.

## Interface
- BITS, 8: operand width in bits; result width is 2*BITS.
- DIM, 32: array dimension, which is also the maximum matrix dimension.
- clk  in  1  single clock; all state is updated on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- en  in  1  compute enable; the array advances only while this is high.
- WrEn  in  1  reserved; ignored by the design, and X-tolerant.
- m  in  $clog2(DIM)+1  number of A rows, which is also the number of C rows.
- n  in  $clog2(DIM)+1  number of B columns, which is also the number of C columns.
- p  in  $clog2(DIM)+1  inner dimension: A columns and B rows.
- matrixDataA  in  [DIM][DIM]×BITS  operand A, indexed [row][col].
- matrixDataB  in  [DIM][DIM]×BITS  operand B, indexed [row][col].
- dataOut  out  [DIM][DIM]×2*BITS  result C, indexed [row][col].
- done  out  1  result-valid flag.

## Operation
- Function: C[i][j] = Σ_{k<p} A[i][k]·B[k][j] for i<m and j<n. All other dataOut entries are 0.
- Arithmetic: unsigned; BITS×BITS products; accumulation is modulo 2^(2*BITS), with no saturation.
- Legal m, n, p values are 1..DIM. Values above DIM are treated as DIM; m, n or p equal to 0 yields an all-zero result.
- Array: a DIM×DIM grid of PEs. Each PE holds an accumulator, an A register that passes the value right and a B register that passes the value down.
- Cycle counter c, with width ≥ $clog2(3*DIM):
  - c increments on each clock edge while en=1 and done=0.
  - c holds while en=0.
- Skewed edge feed during cycle c:
  - Row i left input = A[i][c−i] if i<m and 0≤c−i<p, else 0.
  - Column j top input = B[c−j][j] if j<n and 0≤c−j<p, else 0.
- Per-PE step, on each edge with en=1 and done=0: acc += a_in·b_in; a_out ≤ a_in; b_out ≤ b_in.
- dataOut is the accumulator array itself (registered output).
- done is set when c reaches m+n+p−2. It is sticky, and the accumulators freeze once it is set.
- A new operation requires rst_n=0; there is no other restart path.
- Inputs m, n, p, A and B must be held stable from the first en cycle until done.

## Timing
- Reset: while rst_n=0 at an edge, accumulators, pipeline registers, c and done all clear to 0. dataOut therefore resets to all zeros and done to 0.
- Reset mid-operation aborts the computation; the next edge starts from the cleared state.
- Latency: done is high after exactly m+n+p−2 enabled edges.
  - Full 32×32×32: 94 edges, i.e. 3*DIM−2.
  - 5×5×5: 13 edges.
- dataOut is valid in the same cycle that done is first observed high.
- Stall: when en is low, all state holds, including c, done and the pipeline registers. Resuming en continues the computation with an identical result.
- When en=1 and done=1 at the same time, state holds.

## Structure
- Package matmul_pkg holds BITS and DIM defaults and typedefs:
  - operand_t: BITS wide.
  - acc_t: 2*BITS wide.
  - dim_t: $clog2(DIM)+1 wide.
- Sub-module matmul_pe contains one multiply-accumulate cell:
  - ports: clk, rst_n, step, a_in, b_in, a_out, b_out, acc.
  - step is the shared enable, en & ~done.
- The top level contains the counter, the skew/feed logic, the DIM×DIM generate grid of matmul_pe, and the done logic.

## Test plan
- 5×5×5 random operands (0..100) with random data in unused regions: done after 13 enabled edges; dataOut[i][j] matches the software product for i,j<5; all other entries are 0.
- 32×32×32 all ones: done after 94 edges; every dataOut entry is 32.
- 32×32×32 all 255: every entry is 49184 (2080800 mod 65536), showing the wrap.
- m=3, n=4, p=2 with A[i][k]=i+1 and B[k][j]=j+1: C[i][j]=2(i+1)(j+1); done after 7 edges; rows ≥3 and columns ≥4 are 0.
- 8×8×8 identity A with random B, with en dropped for 5 cycles mid-run: dataOut equals B in the 8×8 corner; done arrives after 22 enabled edges, not 22 clock edges.
- rst_n pulsed low at edge 10 of a 32×32×32 run: dataOut goes to all 0 and done to 0; the rerun completes correctly after 94 edges.
